// File: rtl/zone_palette_painter_if.sv
// Pixel bus between the timing generator (master) and the zone painter (slave).
// Coordinates flow in, registered colour and zone index flow back.
interface zone_palette_painter_if #(
    parameter int COLOR_W = 24,
    parameter int ZI_W    = 2
);
    logic [9:0]         horizontal;
    logic [9:0]         vertical;
    logic [COLOR_W-1:0] color;
    logic [ZI_W-1:0]    zone_out;

    modport master (output horizontal, vertical, input color, zone_out);
    modport slave  (input horizontal, vertical, output color, zone_out);
endinterface

// File: rtl/zone_palette_painter.sv
// Per-zone palette painter: coordinates -> zone -> palette colour, with swap capture and auto-rotation.
// Latency 2 cycles from coordinates to color/zone_out; no backpressure (free-running pixel stream).
module zone_palette_painter #(
    parameter int COLOR_W     = 24,
    parameter int ZONES_X     = 2,
    parameter int ZONES_Y     = 2,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int AUTO_FRAMES = 60,
    localparam int NZ         = ZONES_X * ZONES_Y,
    localparam int ZI_W       = (NZ > 1) ? $clog2(NZ) : 1
) (
    input  logic                   clk_in,
    input  logic                   reset_in,
    input  logic                   swap_in,
    input  logic                   auto_in,
    zone_palette_painter_if.slave  pix,
    output logic [ZI_W-1:0]        wr_ptr_out
);
    localparam int ZW   = H_ACTIVE / ZONES_X;
    localparam int ZH   = V_ACTIVE / ZONES_Y;
    localparam int ZX_W = (ZONES_X > 1) ? $clog2(ZONES_X) : 1;
    localparam int ZY_W = (ZONES_Y > 1) ? $clog2(ZONES_Y) : 1;
    localparam int FC_W = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;

    logic [COLOR_W-1:0] r_gen;
    logic               r_s1, r_s2, r_s3;
    logic [COLOR_W-1:0] r_pal [NZ];
    logic [ZI_W-1:0]    r_wr_ptr;
    logic [FC_W-1:0]    r_frame_cnt;
    logic               r_rot_req;
    logic               r_fs_d;
    logic [ZI_W-1:0]    r_zone1;
    logic               r_act1;
    logic [COLOR_W-1:0] r_color;
    logic [ZI_W-1:0]    r_zone;

    logic               w_swap_pulse;
    logic               w_fs_lvl;
    logic               w_frame_start;
    logic [ZX_W-1:0]    w_zx;
    logic [ZY_W-1:0]    w_zy;
    logic [ZI_W-1:0]    w_zone;
    logic               w_act;

    assign w_swap_pulse  = r_s2 & ~r_s3;
    assign w_fs_lvl      = (pix.horizontal == 10'd0) && (pix.vertical == 10'd0);
    assign w_frame_start = w_fs_lvl & ~r_fs_d;

    // Compare chains: the last threshold passed is the zone, so overflow pixels clamp naturally.
    always_comb begin
        w_zx = '0;
        w_zy = '0;
        for (int k = 1; k < ZONES_X; k++) begin
            if (32'(pix.horizontal) >= k * ZW) w_zx = ZX_W'(k);
        end
        for (int k = 1; k < ZONES_Y; k++) begin
            if (32'(pix.vertical) >= k * ZH) w_zy = ZY_W'(k);
        end
        w_zone = ZI_W'(int'(w_zy) * ZONES_X + int'(w_zx));
        w_act  = (32'(pix.horizontal) < H_ACTIVE) && (32'(pix.vertical) < V_ACTIVE);
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_gen <= '0;
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_s3  <= 1'b0;
        end else begin
            r_gen <= r_gen + 1'b1;
            r_s1  <= swap_in;
            r_s2  <= r_s1;
            r_s3  <= r_s2;
        end
    end

    // A swap write takes the cycle; a pending rotation waits one cycle behind it.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            for (int i = 0; i < NZ; i++) r_pal[i] <= '0;
            r_wr_ptr <= '0;
        end else if (w_swap_pulse) begin
            r_pal[r_wr_ptr] <= r_gen;
            r_wr_ptr        <= (r_wr_ptr == ZI_W'(NZ - 1)) ? '0 : r_wr_ptr + 1'b1;
        end else if (r_rot_req && auto_in) begin
            for (int i = 0; i < NZ; i++) r_pal[i] <= r_pal[(i + 1) % NZ];
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_fs_d      <= 1'b0;
            r_frame_cnt <= '0;
            r_rot_req   <= 1'b0;
        end else begin
            r_fs_d <= w_fs_lvl;
            if (!auto_in) begin
                r_frame_cnt <= '0;
                r_rot_req   <= 1'b0;
            end else begin
                if (r_rot_req && !w_swap_pulse) r_rot_req <= 1'b0;
                if (w_frame_start) begin
                    if (r_frame_cnt == FC_W'(AUTO_FRAMES - 1)) begin
                        r_frame_cnt <= '0;
                        r_rot_req   <= 1'b1;
                    end else begin
                        r_frame_cnt <= r_frame_cnt + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_zone1 <= '0;
            r_act1  <= 1'b0;
            r_color <= '0;
            r_zone  <= '0;
        end else begin
            r_zone1 <= w_zone;
            r_act1  <= w_act;
            r_color <= r_act1 ? r_pal[r_zone1] : '0;
            r_zone  <= r_zone1;
        end
    end

    assign pix.color    = r_color;
    assign pix.zone_out = r_zone;
    assign wr_ptr_out   = r_wr_ptr;
endmodule

// File: tb/tb_zone_palette_painter.sv
// Bench for zone_palette_painter: directed pixel vectors checked through a latency-tagged scoreboard.
module tb_zone_palette_painter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       swap;
    logic       auto_m;
    logic [9:0] h, v;
    logic [1:0] wpa;
    logic [2:0] wpb;

    zone_palette_painter_if #(.COLOR_W(24), .ZI_W(2)) ifa ();
    zone_palette_painter_if #(.COLOR_W(24), .ZI_W(3)) ifb ();
    assign ifa.horizontal = h;
    assign ifa.vertical   = v;
    assign ifb.horizontal = h;
    assign ifb.vertical   = v;

    zone_palette_painter #(.AUTO_FRAMES(2)) dut_a (
        .clk_in(clk), .reset_in(rst), .swap_in(swap), .auto_in(auto_m),
        .pix(ifa.slave), .wr_ptr_out(wpa));
    zone_palette_painter #(.ZONES_X(3)) dut_b (
        .clk_in(clk), .reset_in(rst), .swap_in(swap), .auto_in(auto_m),
        .pix(ifb.slave), .wr_ptr_out(wpb));

    typedef struct {
        int          which;
        bit          cc;
        logic [23:0] col;
        int          zone;
        int          id;
    } exp_t;

    exp_t        q[$];
    exp_t        me;
    logic [23:0] act_col;
    int          act_z;
    int          n_vec = 0;
    int          n_bad = 0;
    int          pid   = 0;
    logic        issue = 1'b0, tg1 = 1'b0, tg2 = 1'b0;
    logic [23:0] cyc;
    logic [23:0] p [4];
    logic [23:0] s, s2v;
    int          xs [7] = '{0, 100, 319, 320, 639, 640, 700};
    int          ys [5] = '{0, 239, 240, 479, 500};

    // Model of the free-running generator: counts edges since reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= '0;
        else     cyc <= cyc + 24'd1;
    end

    always @(posedge clk) begin
        tg1 <= issue;
        tg2 <= tg1;
    end

    always @(negedge clk) begin
        if (tg2) begin
            n_vec++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_underflow: output with no expected entry");
            end else begin
                me      = q.pop_front();
                act_col = (me.which != 0) ? ifb.color : ifa.color;
                act_z   = (me.which != 0) ? int'(ifb.zone_out) : int'(ifa.zone_out);
                if ((me.cc && act_col !== me.col) || act_z != me.zone) begin
                    n_bad++;
                    $display("FAIL pix%0d dut%0d: color=%h zone=%0d, expected color=%h zone=%0d",
                             me.id, me.which, act_col, act_z, me.col, me.zone);
                end
            end
        end
    end

    function automatic int rz(int x, int y, int nx, int ny);
        int a, b;
        a = x / (640 / nx);
        b = y / (480 / ny);
        if (a > nx - 1) a = nx - 1;
        if (b > ny - 1) b = ny - 1;
        return b * nx + a;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        issue = 1'b0;
    endtask

    task automatic pix(input int x, input int y, input int which, input bit cc,
                       input logic [23:0] c, input int z);
        exp_t e;
        @(posedge clk);
        #1;
        h = 10'(x);
        v = 10'(y);
        issue = 1'b1;
        e.which = which; e.cc = cc; e.col = c; e.zone = z; e.id = pid;
        pid++;
        q.push_back(e);
    endtask

    task automatic flush();
        repeat (4) tick();
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_swap(output logic [23:0] val);
        tick();
        swap = 1'b1;
        val  = cyc + 24'd2;
        repeat (3) tick();
        swap = 1'b0;
        repeat (3) tick();
    endtask

    task automatic frame();
        tick(); h = 10'd0; v = 10'd0;
        tick(); tick();
        h = 10'd5; v = 10'd5;
        tick(); tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; swap = 1'b0; auto_m = 1'b0; h = 10'd0; v = 10'd0;
        repeat (3) tick();
        chk("rst_color", int'(ifa.color), 0);
        chk("rst_zone", int'(ifa.zone_out), 0);
        chk("rst_wrptr", int'(wpa), 0);
        rst = 1'b0;

        // Empty palette: every sampled pixel is black.
        foreach (ys[j]) foreach (xs[i]) pix(xs[i], ys[j], 0, 1'b1, 24'd0, rz(xs[i], ys[j], 2, 2));
        flush();
        chk("sweep_wrptr", int'(wpa), 0);

        // Release just before edge 0, raise swap before edge 10, hold 50 cycles.
        rst = 1'b1; tick(); tick();
        rst = 1'b0;
        repeat (10) tick();
        swap = 1'b1;
        tick(); tick();
        chk("wrptr_edge11", int'(wpa), 0);
        tick();
        chk("wrptr_edge12", int'(wpa), 1);
        repeat (47) tick();
        swap = 1'b0;
        repeat (3) tick();
        chk("wrptr_held", int'(wpa), 1);
        pix(100, 100, 0, 1'b1, 24'd12, 0);
        flush();

        // Four swaps fill the 2x2 palette.
        do_reset();
        h = 10'd5; v = 10'd5;
        do_swap(p[0]); chk("wrptr_s1", int'(wpa), 1);
        do_swap(p[1]); chk("wrptr_s2", int'(wpa), 2);
        do_swap(p[2]); chk("wrptr_s3", int'(wpa), 3);
        do_swap(p[3]); chk("wrptr_s4", int'(wpa), 0);
        chk("wrptr_b", int'(wpb), 4);
        pix(0, 0, 0, 1'b1, p[0], 0);
        pix(320, 0, 0, 1'b1, p[1], 1);
        pix(0, 240, 0, 1'b1, p[2], 2);
        pix(639, 479, 0, 1'b1, p[3], 3);
        pix(319, 239, 0, 1'b1, p[0], 0);
        pix(640, 0, 0, 1'b1, 24'd0, 1);
        pix(0, 480, 0, 1'b1, 24'd0, 2);
        pix(212, 0, 1, 1'b1, p[0], 0);
        pix(213, 0, 1, 1'b1, p[1], 1);
        pix(425, 0, 1, 1'b1, p[1], 1);
        pix(426, 0, 1, 1'b1, p[2], 2);
        pix(639, 0, 1, 1'b1, p[2], 2);
        pix(639, 479, 1, 1'b1, 24'd0, 5);
        flush();

        // Auto mode: two frames rotate once; static mode leaves it alone.
        h = 10'd5; v = 10'd5;
        auto_m = 1'b1;
        tick(); tick();
        frame();
        frame();
        tick(); tick();
        auto_m = 1'b0;
        pix(0, 0, 0, 1'b1, p[1], 0);
        pix(320, 0, 0, 1'b1, p[2], 1);
        pix(0, 240, 0, 1'b1, p[3], 2);
        pix(639, 479, 0, 1'b1, p[0], 3);
        flush();
        h = 10'd5; v = 10'd5;
        repeat (10) frame();
        pix(0, 0, 0, 1'b1, p[1], 0);
        pix(639, 479, 0, 1'b1, p[0], 3);
        flush();

        // Swap pulse lands in the same cycle as the rotation request.
        h = 10'd5; v = 10'd5;
        auto_m = 1'b1;
        tick(); tick();
        frame();
        tick();
        swap = 1'b1;
        s = cyc + 24'd2;
        tick(); h = 10'd0; v = 10'd0;
        tick(); h = 10'd5; v = 10'd5;
        tick(); tick(); tick();
        auto_m = 1'b0;
        swap = 1'b0;
        repeat (3) tick();
        chk("wrptr_coinc", int'(wpa), 1);
        pix(0, 0, 0, 1'b1, p[2], 0);
        pix(320, 0, 0, 1'b1, p[3], 1);
        pix(0, 240, 0, 1'b1, p[0], 2);
        pix(639, 479, 0, 1'b1, s, 3);
        flush();

        // Reset mid-frame clears the output at once and drops an in-flight swap.
        pix(0, 0, 0, 1'b1, p[2], 0);
        flush();
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_color", int'(ifa.color), 0);
        chk("midrst_zone", int'(ifa.zone_out), 0);
        chk("midrst_wrptr", int'(wpa), 0);
        tick();
        rst = 1'b0;
        h = 10'd5; v = 10'd5;
        tick();
        swap = 1'b1;
        tick();
        #2;
        rst = 1'b1;
        swap = 1'b0;
        tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("inflight_wrptr", int'(wpa), 0);
        do_swap(s2v);
        chk("post_rst_wrptr", int'(wpa), 1);
        pix(0, 0, 0, 1'b1, s2v, 0);
        pix(320, 0, 0, 1'b1, 24'd0, 1);
        flush();

        chk("sb_drain", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
